// File: rtl/periph_target_pkg.sv
// Shared types for the PERIPH responder: memory op-size encodings, register
// offsets, STATUS bit positions, the TX FSM state type and lane helpers.
// Optional timer block is enabled with the PERIPH_TIMER_EN macro.
package periph_target_pkg;

    // Memory access op-size encodings shared with the memory access unit.
    localparam logic [1:0] MEM_OP_SIZE_BYTE    = 2'd0;
    localparam logic [1:0] MEM_OP_SIZE_HALF    = 2'd1;
    localparam logic [1:0] MEM_OP_SIZE_WORD    = 2'd2;
    localparam logic [1:0] MEM_OP_SIZE_INVALID = 2'd3;

    // Register offsets within the PERIPH region (addr[27:0]).
    localparam logic [27:0] OFF_SCRATCH = 28'h000_0000;
    localparam logic [27:0] OFF_COUNT   = 28'h000_0004;
    localparam logic [27:0] OFF_CMP     = 28'h000_0008;
    localparam logic [27:0] OFF_STATUS  = 28'h000_000C;
    localparam logic [27:0] OFF_TX_DATA = 28'h000_0010;
    localparam logic [27:0] OFF_LAST    = 28'h000_0013;

    // STATUS register bit positions.
    localparam int STATUS_MATCH_BIT   = 0;
    localparam int STATUS_TX_BUSY_BIT = 1;
    localparam int STATUS_IE_BIT      = 2;

    // TX port state: IDLE waits for a TX_DATA store, VALID holds the byte.
    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_VALID = 1'b1
    } tx_state_t;

    // Byte enables for an access of the given size at the given byte lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_OP_SIZE_BYTE: return 4'b0001 << lane;
            MEM_OP_SIZE_HALF: return 4'b0011 << lane;
            MEM_OP_SIZE_WORD: return 4'b1111;
            default:          return 4'b0000;
        endcase
    endfunction

    // Replace the enabled bytes of old with the matching bytes of wdata.
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/periph_target_if.sv
// Bus bundle between the memory access unit (master) and the PERIPH
// responder (slave), plus the byte-wide TX port toward the serializer.
interface periph_target_if;
    logic        enable;
    logic        is_write;
    logic [1:0]  op_size;
    logic [31:0] addr;
    logic [31:0] in;
    logic [31:0] out;
    logic        access_fault;

    // TX handshake: the responder raises tx_valid with tx_data and holds both
    // stable until the cycle tx_valid & tx_ready is seen at posedge clk; that
    // cycle is the transfer. tx_ready may toggle freely and has no effect
    // while tx_valid is low.
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output enable, is_write, op_size, addr, in, tx_ready,
        input  out, access_fault, tx_valid, tx_data
    );

    modport slave (
        input  enable, is_write, op_size, addr, in, tx_ready,
        output out, access_fault, tx_valid, tx_data
    );
endinterface

// File: rtl/periph_timer.sv
// Prescaled up-counter with compare: COUNT advances once every PRESCALE
// clocks, and match latches when an increment lands on CMP.
// Instantiated only when PERIPH_TIMER_EN is defined.
module periph_timer
    import periph_target_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  count_we,
    input  logic [3:0]  cmp_we,
    input  logic [31:0] wdata,
    input  logic        match_clr,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        match
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic          count_wr;
    logic [31:0]   count_inc;
    logic          match_set;

    assign tick      = (pre == PRE_LAST);
    assign count_wr  = |count_we;
    assign count_inc = count + 32'd1;
    // A software COUNT write suppresses both the increment and the compare.
    assign match_set = tick & ~count_wr & (count_inc == cmp);

    // Free-running prescaler; CMP writes deliberately do not touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // COUNT: software write wins over a tick in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count_wr) begin
            count <= byte_merge(count, wdata, count_we);
        end else if (tick) begin
            count <= count_inc;
        end
    end

    // CMP: plain byte-lane register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp <= '0;
        end else if (|cmp_we) begin
            cmp <= byte_merge(cmp, wdata, cmp_we);
        end
    end

    // match: sticky, cleared by W1C, a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match <= 1'b0;
        end else begin
            match <= match_set | (match & ~match_clr);
        end
    end
endmodule

// File: rtl/periph_target.sv
// PERIPH region responder: SCRATCH register, optional prescaled timer
// (COUNT/CMP/match/ie, enabled by PERIPH_TIMER_EN) and a one-byte TX port.
// Reads are combinational; writes commit at posedge clk when not faulted.
module periph_target
    import periph_target_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter logic [3:0]  REGION   = 4'h3
) (
    input  logic             clk,
    input  logic             reset_n,
    periph_target_if.slave   bus,
    output logic             timer_irq,
    output tx_state_t        tx_state_dbg
);
    logic [27:0] offset;
    logic [1:0]  lane;
    logic        sel_scratch, sel_count, sel_cmp, sel_status, sel_tx;
    logic        bad;
    logic        commit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rshift;

    logic [31:0] scratch;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic        ie;

    tx_state_t   tx_state;
    logic        tx_valid;
    logic [7:0]  tx_data;

    assign offset      = bus.addr[27:0];
    assign lane        = bus.addr[1:0];
    assign sel_scratch = (offset[27:2] == OFF_SCRATCH[27:2]);
    assign sel_count   = (offset[27:2] == OFF_COUNT[27:2]);
    assign sel_cmp     = (offset[27:2] == OFF_CMP[27:2]);
    assign sel_status  = (offset[27:2] == OFF_STATUS[27:2]);
    assign sel_tx      = (offset[27:2] == OFF_TX_DATA[27:2]);

    // Collect every reason to reject the access; gated by enable below.
    always_comb begin
        bad = 1'b0;
        if (bus.addr[31:28] != REGION)                          bad = 1'b1;
        if (offset > OFF_LAST)                                  bad = 1'b1;
        if (bus.op_size == MEM_OP_SIZE_INVALID)                 bad = 1'b1;
        if (bus.op_size == MEM_OP_SIZE_HALF && lane[0])         bad = 1'b1;
        if (bus.op_size == MEM_OP_SIZE_WORD && lane != 2'd0)    bad = 1'b1;
        if (sel_tx && !bus.is_write)                            bad = 1'b1;
        if (sel_tx && bus.is_write && lane != 2'd0)             bad = 1'b1;
        if (sel_tx && bus.is_write && tx_valid)                 bad = 1'b1;
`ifndef PERIPH_TIMER_EN
        if (sel_count || sel_cmp)                               bad = 1'b1;
`endif
    end

    assign bus.access_fault = bus.enable & bad;
    assign commit           = bus.enable & bus.is_write & ~bad;
    assign be               = lane_mask(bus.op_size, lane);
    assign wdata            = bus.in << {lane, 3'b000};

    // Register read mux, then right-justify the addressed lanes.
    always_comb begin
        rdata = 32'h0;
        if (sel_scratch) rdata = scratch;
        if (sel_count)   rdata = count;
        if (sel_cmp)     rdata = cmp;
        if (sel_status)  rdata = {29'h0, ie, tx_valid, match};
        rshift = rdata >> {lane, 3'b000};
        bus.out = 32'h0;
        if (bus.enable && !bad) begin
            case (bus.op_size)
                MEM_OP_SIZE_BYTE: bus.out = {24'h0, rshift[7:0]};
                MEM_OP_SIZE_HALF: bus.out = {16'h0, rshift[15:0]};
                default:          bus.out = rshift;
            endcase
        end
    end

    // SCRATCH: byte-lane RW register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
        end else if (commit && sel_scratch) begin
            scratch <= byte_merge(scratch, wdata, be);
        end
    end

`ifdef PERIPH_TIMER_EN
    periph_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .count_we  ({4{commit & sel_count}} & be),
        .cmp_we    ({4{commit & sel_cmp}} & be),
        .wdata     (wdata),
        .match_clr (commit & sel_status & be[0] & wdata[STATUS_MATCH_BIT]),
        .count     (count),
        .cmp       (cmp),
        .match     (match)
    );

    // Interrupt enable lives in STATUS lane 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie <= 1'b0;
        end else if (commit && sel_status && be[0]) begin
            ie <= wdata[STATUS_IE_BIT];
        end
    end

    assign timer_irq = match & ie;
`else
    assign count     = 32'h0;
    assign cmp       = 32'h0;
    assign match     = 1'b0;
    assign ie        = 1'b0;
    assign timer_irq = 1'b0;
`endif

    // TX FSM: latch the byte on a committed TX_DATA store, drop it on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (commit && sel_tx) begin
                        tx_state <= TX_VALID;
                        tx_valid <= 1'b1;
                        tx_data  <= bus.in[7:0];
                    end
                end
                TX_VALID: begin
                    if (bus.tx_ready) begin
                        tx_state <= TX_IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = tx_data;
    assign tx_state_dbg = tx_state;
endmodule

// File: tb/tb_periph_target.sv
// Bench for periph_target: directed scenarios followed by random accesses,
// all checked against a register-level reference model. Timer checks adapt
// to whether PERIPH_TIMER_EN is defined.
module tb_periph_target;
    import periph_target_pkg::*;

    localparam int PRESCALE = 4;
`ifdef PERIPH_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      reset_n = 1'b1;
    logic      timer_irq;
    tx_state_t tx_state_dbg;

    periph_target_if bus_if ();

    periph_target #(
        .PRESCALE (PRESCALE),
        .REGION   (4'h3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus_if),
        .timer_irq    (timer_irq),
        .tx_state_dbg (tx_state_dbg)
    );

    // Clock and watchdog.
    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_scratch, m_count, m_cmp;
    logic        m_match, m_ie, m_txv;
    logic [7:0]  m_txd;
    int          m_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_scratch = '0; m_count = '0; m_cmp = '0;
        m_match = 1'b0; m_ie = 1'b0; m_txv = 1'b0; m_txd = 8'h00; m_pre = 0;
    endtask

    function automatic logic m_fault(input logic en, input logic wr, input logic [1:0] sz,
                                     input logic [31:0] a);
        logic [27:0] off;
        logic tx, tmr;
        off = a[27:0];
        tx  = (off >= 28'h10) && (off <= 28'h13);
        tmr = (off >= 28'h04) && (off <= 28'h0B);
        if (!en) return 1'b0;
        return (a[31:28] != 4'h3) || (off > 28'h13) || (sz == 2'd3) ||
               (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               (tx && !wr) || (tx && wr && a[1:0] != 2'd0) || (tx && wr && m_txv) ||
               (!TIMER && tmr);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] w;
        case (a[4:2])
            3'd0:    w = m_scratch;
            3'd1:    w = m_count;
            3'd2:    w = m_cmp;
            3'd3:    w = {29'h0, m_ie, m_txv, m_match};
            default: w = 32'h0;
        endcase
        w = w >> (8 * a[1:0]);
        if (sz == 2'd0) return w & 32'h0000_00ff;
        if (sz == 2'd1) return w & 32'h0000_ffff;
        return w;
    endfunction

    // Advance the model across one clock edge using the pre-edge state.
    task automatic m_commit(input logic en, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d, input logic rdy,
                            input logic ef);
        logic commit, tick, set, clr;
        logic [31:0] mask, sd;
        int idx;
        commit = en && wr && !ef;
        case (sz)
            2'd0:    mask = 32'h0000_00ff << (8 * a[1:0]);
            2'd1:    mask = 32'h0000_ffff << (8 * a[1:0]);
            default: mask = 32'hffff_ffff;
        endcase
        sd   = d << (8 * a[1:0]);
        idx  = int'(a[4:2]);
        tick = TIMER && (m_pre == PRESCALE - 1);
        set  = 1'b0;
        clr  = 1'b0;
        if (TIMER) m_pre = tick ? 0 : m_pre + 1;
        if (commit && idx == 1) begin
            m_count = (m_count & ~mask) | (sd & mask);
        end else if (tick) begin
            m_count = m_count + 32'd1;
            if (m_count == m_cmp) set = 1'b1;
        end
        if (commit && idx == 2) m_cmp = (m_cmp & ~mask) | (sd & mask);
        if (commit && idx == 3) begin
            clr = sd[0] & mask[0];
            if (TIMER && mask[2]) m_ie = sd[2];
        end
        m_match = set | (m_match & ~clr);
        if (commit && idx == 0) m_scratch = (m_scratch & ~mask) | (sd & mask);
        if (commit && idx == 4) begin
            m_txv = 1'b1;
            m_txd = d[7:0];
        end else if (m_txv && rdy) begin
            m_txv = 1'b0;
        end
    endtask

    // One bus cycle: drive at posedge+1, check combinational outputs before
    // the edge, update the model at the edge, then check registered outputs.
    task automatic step(input logic en, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic rdy,
                        output logic [31:0] o_out, output logic o_fault);
        logic ef;
        logic [31:0] eo;
        bus_if.enable   = en;
        bus_if.is_write = wr;
        bus_if.op_size  = sz;
        bus_if.addr     = a;
        bus_if.in       = d;
        bus_if.tx_ready = rdy;
        #2;
        ef      = m_fault(en, wr, sz, a);
        eo      = m_read(sz, a);
        o_out   = bus_if.out;
        o_fault = bus_if.access_fault;
        check("access_fault", 32'(o_fault), 32'(ef));
        if (!en) check("out_idle", o_out, 32'h0);
        else if (!wr && !ef) check("out_read", o_out, eo);
        @(posedge clk);
        m_commit(en, wr, sz, a, d, rdy, ef);
        #1;
        check("tx_valid", 32'(bus_if.tx_valid), 32'(m_txv));
        check("tx_data", 32'(bus_if.tx_data), 32'(m_txd));
        check("timer_irq", 32'(timer_irq), 32'(m_match & m_ie));
        check("tx_state", 32'(tx_state_dbg), 32'(m_txv ? TX_VALID : TX_IDLE));
    endtask

    task automatic do_reset();
        bus_if.enable   = 1'b0;
        bus_if.is_write = 1'b0;
        bus_if.op_size  = 2'd0;
        bus_if.addr     = 32'h0;
        bus_if.in       = 32'h0;
        bus_if.tx_ready = 1'b0;
        reset_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [31:0] o;
    logic        f;

    initial begin
        #2;
        do_reset();

        // Reset state.
        #1;
        check("rst_out", bus_if.out, 32'h0);
        check("rst_fault", 32'(bus_if.access_fault), 32'h0);
        check("rst_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        check("rst_tx_data", 32'(bus_if.tx_data), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        @(posedge clk); #1;
        m_commit(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // SCRATCH word write and byte read.
        step(1, 1, 2'd2, 32'h3000_0000, 32'hdead_beef, 0, o, f);
        step(1, 0, 2'd0, 32'h3000_0002, 32'h0, 0, o, f);
        check("byte_read", o, 32'h0000_00ad);
        check("byte_read_fault", 32'(f), 32'h0);

        // Half-word write to the upper lanes.
        step(1, 1, 2'd1, 32'h3000_0002, 32'h0000_1234, 0, o, f);
        step(1, 0, 2'd2, 32'h3000_0000, 32'h0, 0, o, f);
        check("half_merge", o, 32'h1234_beef);

        // Faulting accesses leave SCRATCH untouched.
        step(1, 1, 2'd2, 32'h3000_0006, 32'h1111_1111, 0, o, f);
        check("misaligned_fault", 32'(f), 32'h1);
        step(1, 1, 2'd2, 32'h2000_0000, 32'h2222_2222, 0, o, f);
        check("region_fault", 32'(f), 32'h1);
        step(1, 1, 2'd2, 32'h3000_0014, 32'h3333_3333, 0, o, f);
        check("range_fault", 32'(f), 32'h1);
        step(1, 1, 2'd3, 32'h3000_0000, 32'h4444_4444, 0, o, f);
        check("opsize_fault", 32'(f), 32'h1);
        step(1, 0, 2'd2, 32'h3000_0000, 32'h0, 0, o, f);
        check("scratch_kept", o, 32'h1234_beef);

        // TX byte, busy fault, handshake.
        step(1, 0, 2'd2, 32'h3000_0010, 32'h0, 0, o, f);
        check("tx_read_fault", 32'(f), 32'h1);
        step(1, 1, 2'd2, 32'h3000_0010, 32'h0000_0041, 0, o, f);
        check("tx_valid_set", 32'(bus_if.tx_valid), 32'h1);
        check("tx_data_set", 32'(bus_if.tx_data), 32'h41);
        step(1, 1, 2'd2, 32'h3000_0010, 32'h0000_0042, 0, o, f);
        check("tx_busy_fault", 32'(f), 32'h1);
        step(1, 0, 2'd2, 32'h3000_000C, 32'h0, 0, o, f);
        check("status_busy", o, 32'h2);
        step(0, 0, 2'd0, 32'h0, 32'h0, 1, o, f);
        check("tx_released", 32'(bus_if.tx_valid), 32'h0);
        step(1, 0, 2'd2, 32'h3000_000C, 32'h0, 0, o, f);
        check("status_idle", o, 32'h0);

        // Timer: CMP=3, ie=1, match on the 12th edge after release.
        do_reset();
`ifdef PERIPH_TIMER_EN
        step(1, 1, 2'd2, 32'h3000_0008, 32'h3, 0, o, f);
        step(1, 1, 2'd2, 32'h3000_000C, 32'h4, 0, o, f);
        for (int k = 3; k <= 12; k++) begin
            step(0, 0, 2'd0, 32'h0, 32'h0, 0, o, f);
            check($sformatf("irq_edge_%0d", k), 32'(timer_irq), (k == 12) ? 32'h1 : 32'h0);
        end
        step(1, 1, 2'd2, 32'h3000_000C, 32'h5, 0, o, f);
        check("irq_cleared", 32'(timer_irq), 32'h0);
        step(1, 0, 2'd2, 32'h3000_000C, 32'h0, 0, o, f);
        check("status_after_w1c", o, 32'h4);
`else
        step(1, 1, 2'd2, 32'h3000_0004, 32'h5, 0, o, f);
        check("count_fault", 32'(f), 32'h1);
        step(1, 0, 2'd2, 32'h3000_0008, 32'h0, 0, o, f);
        check("cmp_fault", 32'(f), 32'h1);
        step(1, 1, 2'd2, 32'h3000_000C, 32'h5, 0, o, f);
        step(1, 0, 2'd2, 32'h3000_000C, 32'h0, 0, o, f);
        check("status_no_timer", o, 32'h0);
        check("irq_tied", 32'(timer_irq), 32'h0);
`endif

        // Random accesses against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rg;
            logic [27:0] off;
            rg  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h3;
            off = ($urandom_range(0, 19) == 0) ? 28'($urandom) : 28'($urandom_range(0, 23));
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), {rg, off}, $urandom, 1'($urandom_range(0, 1)), o, f);
        end

        // Reset in the middle of a pending TX byte.
        do_reset();
        step(1, 1, 2'd0, 32'h3000_0010, 32'h0000_005a, 0, o, f);
        step(1, 1, 2'd2, 32'h3000_0000, 32'hcafe_f00d, 0, o, f);
        check("tx_pending", 32'(bus_if.tx_valid), 32'h1);
        bus_if.enable   = 1'b1;
        bus_if.is_write = 1'b0;
        bus_if.op_size  = 2'd2;
        bus_if.addr     = 32'h3000_0000;
        reset_n = 1'b0;
        #1;
        check("async_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        check("async_out", bus_if.out, 32'h0);
        check("async_state", 32'(tx_state_dbg), 32'(TX_IDLE));
`ifdef PERIPH_TIMER_EN
        bus_if.addr = 32'h3000_0004;
        #1;
        check("async_count", bus_if.out, 32'h0);
`endif
        do_reset();
        step(1, 0, 2'd2, 32'h3000_0000, 32'h0, 0, o, f);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
